// File: rtl/plot_arbiter.sv
// plot_arbiter
//   Shares the single VGA-adapter pixel write port between NUM_REQ pixel
//   producers (snake datapath, food drawer, score/border painter, ...).
//   A round-robin arbiter grants one requester at a time. The grant is held
//   for a burst of up to MAX_BURST pixels. Each consumed pixel is
//   acknowledged combinationally and appears on the registered VGA port one
//   cycle later. Off-screen pixels are consumed without a write strobe.
//
//   Optional feature, compiled in with `define PLOT_ARB_CLEAR_EN:
//   a full-screen clear engine. It pre-empts the arbiter and sweeps every
//   on-screen pixel in clear_colour.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   req             per-requester request, held while a pixel is presented
//   x_in/y_in/colour_in  packed per-requester pixel (8/7/3 bits each)
//   gnt             registered one-hot grant
//   ack             combinational per-pixel acknowledge
//   x, y, colour, plotEn  registered VGA write port
//   busy            high when not IDLE
//   clear_start, clear_colour, clear_busy  (PLOT_ARB_CLEAR_EN only)
module plot_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int MAX_BURST = 64,
  parameter int SCR_W     = 160,
  parameter int SCR_H     = 120
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   x_in,
  input  logic [7*NUM_REQ-1:0]   y_in,
  input  logic [3*NUM_REQ-1:0]   colour_in,
`ifdef PLOT_ARB_CLEAR_EN
  input  logic                   clear_start,
  input  logic [2:0]             clear_colour,
  output logic                   clear_busy,
`endif
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     ack,
  output logic [7:0]             x,
  output logic [6:0]             y,
  output logic [2:0]             colour,
  output logic                   plotEn,
  output logic                   busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [8:0] XLIM = 9'(SCR_W);
  localparam logic [7:0] YLIM = 8'(SCR_H);

`ifdef PLOT_ARB_CLEAR_EN
  typedef enum logic [1:0] {IDLE, GRANT, CLEAR} state_t;
  localparam logic [7:0] XMAX = 8'(SCR_W - 1);
  localparam logic [6:0] YMAX = 7'(SCR_H - 1);
`else
  typedef enum logic [1:0] {IDLE, GRANT} state_t;
`endif

  state_t            state, state_nxt;
  logic [IW-1:0]     g_idx;
  logic [IW-1:0]     rr_ptr;
  logic [7:0]        burst_cnt;
  logic [IW-1:0]     win_idx;
  logic [IW-1:0]     cand;
  logic              win_found;
  logic [7:0]        x_sel;
  logic [6:0]        y_sel;
  logic [2:0]        c_sel;
  logic              on_screen;
  logic              clear_hit;
  logic              ack_now;
  logic              last_pix;
  logic              burst_end;

  // Burst counter saturates at MAX_BURST.
  function automatic logic [7:0] burst_inc(input logic [7:0] c);
    if (int'(c) >= MAX_BURST) return c;
    return c + 8'd1;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] i);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] i);
    if (int'(i) == NUM_REQ - 1) return '0;
    return i + 1'b1;
  endfunction

  // Round-robin search: scan downward so the lowest offset from rr_ptr
  // is the last (winning) assignment.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IW'((int'(rr_ptr) + k) % NUM_REQ);
      if (req[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  assign x_sel     = x_in[int'(g_idx)*8 +: 8];
  assign y_sel     = y_in[int'(g_idx)*7 +: 7];
  assign c_sel     = colour_in[int'(g_idx)*3 +: 3];
  assign on_screen = ({1'b0, x_sel} < XLIM) && ({1'b0, y_sel} < YLIM);

`ifdef PLOT_ARB_CLEAR_EN
  logic [7:0] cx;
  logic [6:0] cy;
  logic [2:0] clr_col;
  logic       clear_last;
  // A clear request while already clearing is ignored.
  assign clear_hit  = clear_start && (state != CLEAR);
  assign clear_last = (state == CLEAR) && (cx == XMAX) && (cy == YMAX);
  assign clear_busy = (state == CLEAR);
`else
  assign clear_hit  = 1'b0;
`endif

  // A clear request steals the cycle, so no pixel is consumed alongside it.
  assign ack_now   = (state == GRANT) && req[g_idx] && !clear_hit && !rst;
  assign ack       = gnt & {NUM_REQ{ack_now}};
  assign last_pix  = ack_now && (int'(burst_cnt) + 1 >= MAX_BURST);
  assign burst_end = (state == GRANT) && (!req[g_idx] || last_pix || clear_hit);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (clear_hit)      state_nxt = state_t'(2);
        else if (win_found) state_nxt = GRANT;
      end
      GRANT: begin
        if (clear_hit)      state_nxt = state_t'(2);
        else if (burst_end) state_nxt = IDLE;
      end
`ifdef PLOT_ARB_CLEAR_EN
      CLEAR: begin
        if (clear_last) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---- output stage: registered VGA port, grant and burst bookkeeping ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt       <= '0;
      g_idx     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      x         <= '0;
      y         <= '0;
      colour    <= '0;
      plotEn    <= 1'b0;
`ifdef PLOT_ARB_CLEAR_EN
      cx        <= '0;
      cy        <= '0;
      clr_col   <= '0;
`endif
    end else begin
      plotEn <= 1'b0;
      if (ack_now) begin
        x         <= x_sel;
        y         <= y_sel;
        colour    <= c_sel;
        plotEn    <= on_screen;
        burst_cnt <= burst_inc(burst_cnt);
      end
      if (state == IDLE && state_nxt == GRANT) begin
        gnt       <= onehot(win_idx);
        g_idx     <= win_idx;
        burst_cnt <= '0;
      end
      if (burst_end) begin
        gnt    <= '0;
        rr_ptr <= next_ptr(g_idx);
      end
`ifdef PLOT_ARB_CLEAR_EN
      if (clear_hit) begin
        clr_col <= clear_colour;
        cx      <= '0;
        cy      <= '0;
      end
      // Raster sweep: x inner, y outer, one pixel per cycle.
      if (state == CLEAR) begin
        x      <= cx;
        y      <= cy;
        colour <= clr_col;
        plotEn <= 1'b1;
        if (cx == XMAX) begin
          cx <= '0;
          cy <= cy + 7'd1;
        end else begin
          cx <= cx + 8'd1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_plot_arbiter.sv
module tb_plot_arbiter;
  localparam int N    = 3;
  localparam int MAXB = 4;
  localparam int W    = 160;
  localparam int H    = 120;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req = '0;
  logic [8*N-1:0]   x_in = '0;
  logic [7*N-1:0]   y_in = '0;
  logic [3*N-1:0]   colour_in = '0;
  logic [N-1:0]     gnt, ack;
  logic [7:0]       x;
  logic [6:0]       y;
  logic [2:0]       colour;
  logic             plotEn, busy;
`ifdef PLOT_ARB_CLEAR_EN
  logic             clear_start = 1'b0;
  logic [2:0]       clear_colour = 3'b000;
  logic             clear_busy;
`endif

  always #5 clk = ~clk;

  plot_arbiter #(.NUM_REQ(N), .MAX_BURST(MAXB), .SCR_W(W), .SCR_H(H)) dut (
    .clk(clk), .rst(rst), .req(req), .x_in(x_in), .y_in(y_in),
    .colour_in(colour_in),
`ifdef PLOT_ARB_CLEAR_EN
    .clear_start(clear_start), .clear_colour(clear_colour), .clear_busy(clear_busy),
`endif
    .gnt(gnt), .ack(ack), .x(x), .y(y), .colour(colour), .plotEn(plotEn), .busy(busy)
  );

  typedef struct {
    int         due;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model state: mode 0 idle, 1 granted to owner, 2 clearing.
  int         mode = 0;
  int         owner = 0;
  int         cnt = 0;
  int         rr = 0;
  int         clr_k = 0;
  logic [2:0] clr_c = '0;

  // Requester agents.
  bit         pres[N];
  bit         en[N];
  logic [7:0] px[N];
  logic [6:0] py[N];
  logic [2:0] pc[N];
  bit         cs_req = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic newpix(input int i);
    int r;
    r = $urandom_range(0, 15);
    px[i] = (r == 0) ? 8'd160 : (r == 1) ? 8'd159 : (r == 2) ? 8'd255 : 8'($urandom_range(0, 159));
    r = $urandom_range(0, 15);
    py[i] = (r == 0) ? 7'd120 : (r == 1) ? 7'd119 : (r == 2) ? 7'd127 : 7'($urandom_range(0, 119));
    pc[i] = 3'($urandom_range(0, 7));
  endtask

  // Scoreboard monitor: every plot strobe must match the oldest expected
  // write, due exactly on this cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL plot_missing: got plotEn=0, want write (%0d,%0d) c=%0d due cycle %0d",
                 sb[0].x, sb[0].y, sb[0].c, sb[0].due);
        void'(sb.pop_front());
      end
      if (plotEn) begin
        if (sb.size() == 0 || sb[0].due != cyc) begin
          checks++;
          errors++;
          $display("FAIL plot_extra: got plotEn=1 at (%0d,%0d) cycle %0d, want plotEn=0", x, y, cyc);
        end else begin
          e = sb.pop_front();
          chk("plot_x", 32'(x), 32'(e.x));
          chk("plot_y", 32'(y), 32'(e.y));
          chk("plot_colour", 32'(colour), 32'(e.c));
        end
      end
    end
  end

  // One clock cycle: drive agents after the edge, then at the falling edge
  // compare against the model and advance it.
  task automatic cycle();
    logic [N-1:0] ea, eg;
    logic         cs;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (!en[i]) pres[i] = 1'b0;
      else if (pres[i] && $urandom_range(0, 19) == 0) pres[i] = 1'b0;
      else if (!pres[i] && $urandom_range(0, 9) < 7) begin
        pres[i] = 1'b1;
        newpix(i);
      end
      req[i] = pres[i];
      x_in[8*i +: 8] = px[i];
      y_in[7*i +: 7] = py[i];
      colour_in[3*i +: 3] = pc[i];
    end
`ifdef PLOT_ARB_CLEAR_EN
    clear_start = cs_req;
    cs_req = 1'b0;
`endif
    @(negedge clk);
`ifdef PLOT_ARB_CLEAR_EN
    cs = clear_start;
    chk("clear_busy", 32'(clear_busy), 32'(mode == 2));
`else
    cs = 1'b0;
`endif
    eg = '0;
    if (mode == 1) eg[owner] = 1'b1;
    ea = '0;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("busy", 32'(busy), 32'(mode != 0));
    case (mode)
      0: begin
        if (cs) begin
          mode = 2; clr_k = 0;
`ifdef PLOT_ARB_CLEAR_EN
          clr_c = clear_colour;
`endif
        end else if (req != '0) begin
          for (int k = 0; k < N; k++) begin
            if (req[(rr + k) % N]) begin
              owner = (rr + k) % N;
              break;
            end
          end
          cnt = 0;
          mode = 1;
        end
      end
      1: begin
        if (cs) begin
          rr = (owner + 1) % N; mode = 2; clr_k = 0;
`ifdef PLOT_ARB_CLEAR_EN
          clr_c = clear_colour;
`endif
        end else if (req[owner]) begin
          ea[owner] = 1'b1;
          cnt++;
          if (px[owner] < W && py[owner] < H)
            sb.push_back('{cyc + 1, px[owner], py[owner], pc[owner]});
          pres[owner] = 1'b0;
          if (cnt == MAXB) begin
            rr = (owner + 1) % N;
            mode = 0;
          end
        end else begin
          rr = (owner + 1) % N;
          mode = 0;
        end
      end
      default: begin
        sb.push_back('{cyc + 1, 8'(clr_k % W), 7'(clr_k / W), clr_c});
        clr_k++;
        if (clr_k == W * H) mode = 0;
      end
    endcase
    chk("ack", 32'(ack), 32'(ea));
  endtask

  initial begin
    bit hit;
    for (int i = 0; i < N; i++) begin
      en[i] = 1'b1;
      pres[i] = 1'b0;
      px[i] = '0; py[i] = '0; pc[i] = '0;
    end

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_plotEn", 32'(plotEn), 0);
    chk("rst_x", 32'(x), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_colour", 32'(colour), 0);
    chk("rst_busy", 32'(busy), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Randomized contention with bursts, drops and off-screen pixels.
    for (int n = 0; n < 1500; n++) cycle();

    // Asynchronous reset in the middle of a burst.
    hit = 1'b0;
    for (int n = 0; n < 200 && !hit; n++) begin
      cycle();
      if (mode == 1 && cnt >= 1) hit = 1'b1;
    end
    chk("midburst_found", 32'(hit), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ack", 32'(ack), 0);
    chk("midrst_gnt", 32'(gnt), 0);
    chk("midrst_plotEn", 32'(plotEn), 0);
    chk("midrst_x", 32'(x), 0);
    chk("midrst_y", 32'(y), 0);
    chk("midrst_colour", 32'(colour), 0);
    chk("midrst_busy", 32'(busy), 0);
    req = '0;
    for (int i = 0; i < N; i++) pres[i] = 1'b0;
    sb.delete();
    mode = 0; rr = 0; cnt = 0;
    @(posedge clk);
    #1 rst = 1'b0;

    // Only requester 0 after reset, then full contention again.
    en[1] = 1'b0; en[2] = 1'b0;
    for (int n = 0; n < 20; n++) cycle();
    en[1] = 1'b1; en[2] = 1'b1;
    for (int n = 0; n < 500; n++) cycle();

`ifdef PLOT_ARB_CLEAR_EN
    // Clear pre-empting a requester-0 burst, colour latched at start.
    en[1] = 1'b0; en[2] = 1'b0;
    hit = 1'b0;
    for (int n = 0; n < 200 && !hit; n++) begin
      cycle();
      if (mode == 1 && owner == 0) hit = 1'b1;
    end
    chk("clear_owner0_found", 32'(hit), 1);
    clear_colour = 3'b000;
    cs_req = 1'b1;
    cycle();
    cycle();
    clear_colour = 3'b111;
    en[1] = 1'b1; en[2] = 1'b1;
    for (int n = 0; n < 100; n++) cycle();
    cs_req = 1'b1;
    hit = 1'b0;
    for (int n = 0; n < 20000 && !hit; n++) begin
      cycle();
      if (mode != 2) hit = 1'b1;
    end
    chk("clear_done", 32'(hit), 1);
    for (int n = 0; n < 300; n++) cycle();
`endif

    // Drain: no requesters, every expected write must have appeared.
    for (int i = 0; i < N; i++) en[i] = 1'b0;
    for (int n = 0; n < 20; n++) cycle();
    chk("sb_empty", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/plot_arbiter.md
Name: plot_arbiter

Overview:
- Shares the single VGA-adapter pixel write port (x, y, colour, plotEn) between several pixel producers: snake datapath, food drawer, score/border painter.
- Round-robin arbiter with burst lock and per-pixel acknowledge.
- Registered single output port feeds the VGA adapter directly.
- Optional built-in full-screen clear engine.

Parameters:
- NUM_REQ, 3: number of requesters (2..8).
- MAX_BURST, 64: max pixels per grant before forced re-arbitration (1..255).
- SCR_W, 160: screen width; x >= SCR_W is off-screen.
- SCR_H, 120: screen height; y >= SCR_H is off-screen.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request; held high while a pixel is presented.
- x_in  in  8*NUM_REQ  pixel x, requester i at [8i+7:8i].
- y_in  in  7*NUM_REQ  pixel y, requester i at [7i+6:7i].
- colour_in  in  3*NUM_REQ  pixel colour, requester i at [3i+2:3i].
- gnt  out  NUM_REQ  registered one-hot grant.
- ack  out  NUM_REQ  combinational; ack[i]=1 means requester i's pixel is consumed this cycle and it may advance.
- x  out  8  registered pixel x to VGA.
- y  out  7  registered pixel y to VGA.
- colour  out  3  registered pixel colour to VGA.
- plotEn  out  1  registered write strobe to VGA.
- busy  out  1  high when not IDLE.

Behaviour:
- Reset (async, any time, including mid-burst): state=IDLE, gnt=0, plotEn=0, x=0, y=0, colour=0, busy=0, rr_ptr=0, burst count=0. ack is 0 while rst=1.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the first requester with req high, searching upward from rst_ptr and wrapping.
  - Register gnt=one-hot(winner), clear burst count, go to GRANT.
  - No ack in the arbitration cycle.
- GRANT, granted index g:
  - If req[g]=1: ack[g]=1 combinationally. Next edge registers x_in[g], y_in[g], colour_in[g] to the outputs; plotEn=1 unless the pixel is off-screen; burst count increments.
  - Pixel latency from ack to plotEn is exactly 1 cycle.
  - Off-screen pixels (x>=SCR_W or y>=SCR_H) are acked and consumed; plotEn=0 for that pixel.
- Burst end: burst ends when req[g]=0 in GRANT (no ack that cycle), or on the cycle the MAX_BURST-th pixel is acked.
- On burst end:
  - Set rr_ptr=(g+1) mod NUM_REQ, gnt=0, go to IDLE.
  - Re-arbitration costs one idle cycle, so back-to-back bursts have a 1-cycle gap.
- plotEn is 0 in every cycle not following an ack. ack never goes to a non-granted requester. At most one ack bit is high per cycle.
- Simultaneous requests in IDLE: lowest index at or above rr_ptr wins. The others wait; their inputs are ignored until granted.
- A requester dropping req mid-burst forfeits the rest of its burst; it re-requests and waits its turn.
- Burst count is 8 bits and saturates at MAX_BURST.
- busy=1 in GRANT (and CLEAR when compiled in).

Optional Feature:
- Macro: PLOT_ARB_CLEAR_EN.
- When defined, adds three ports:
  - clear_start in 1: one-cycle pulse.
  - clear_colour in 3.
  - clear_busy out 1.
- Adds state CLEAR, which has priority over all requesters:
  - clear_start in IDLE enters CLEAR next edge.
  - clear_start in GRANT ends the burst immediately: gnt=0 next edge, no ack that cycle, rr_ptr advanced as on normal burst end.
  - CLEAR sweeps y 0..SCR_H-1 (outer) and x 0..SCR_W-1 (inner). plotEn=1 with colour=clear_colour latched at start, one pixel per cycle.
  - Default sweep is 19200 pixels. Last pixel (159,119), then IDLE.
  - clear_start during CLEAR is ignored. clear_busy=1 throughout CLEAR. No acks during CLEAR.
- When undefined: ports, state and logic are absent. Behaviour is identical to the above with no clear.

Test Plan:
- Reset mid-burst: assert rst during GRANT → all outputs 0 immediately, ack=0; after release, req=3'b001 → gnt=001 after 1 cycle.
- Single requester: req[0] high for 5 pixels (10,20,c=4)..(14,20) → 5 consecutive ack[0] pulses; plotEn high 5 cycles, each 1 cycle after its ack, with matching x/y/colour.
- Round-robin: req=3'b111 held, MAX_BURST=4 → grants rotate 0,1,2,0. Each burst is 4 pixels with a 1-cycle gap between bursts.
- Off-screen: requester 1 sends (160,5) then (159,119) → both acked; plotEn=0 for the first, 1 for the second.
- Early release: req[2] drops after 2 pixels → burst ends; next grant goes to requester 0 (rr_ptr=0) if requesting.
- PLOT_ARB_CLEAR_EN: clear_start during requester-0 burst, clear_colour=3'b000 → gnt=0 next cycle; 19200 plotEn cycles ending at (159,119); clear_busy falls; arbitration resumes from requester 1.
